rtx_lane_scheduler: RTL and testbench
=====================================

RTX_LANE_SCHEDULER -- requirements
Module: rtx_lane_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, meaning frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 720, meaning frame height in pixels.
REQ-003 SHALL have parameter NUM_LANES, default 4, meaning number of tracer lanes scheduled (2..8).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse requesting a new frame.
REQ-007 SHALL have port busy  output  1  high from frame acceptance until frame_done.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse when the last pixel is written.
REQ-009 SHALL have port lane_ready  input  NUM_LANES  lane i idle and able to accept a pixel.
REQ-010 SHALL have port lane_issue  output  NUM_LANES  one-hot, one-cycle pulse assigning the issue coordinates to lane i.
REQ-011 SHALL have ports issue_h  output  11  and issue_v  output  10  pixel coordinates, valid with lane_issue.
REQ-012 SHALL have port lane_done  input  NUM_LANES  lane i result valid; held until acked.
REQ-013 SHALL have ports lane_pixel  input  16*NUM_LANES, lane_h  input  11*NUM_LANES, lane_v  input  10*NUM_LANES  per-lane RGB565 result and coordinates, packed lane 0 in LSBs.
REQ-014 SHALL have port lane_ack  output  NUM_LANES  one-hot, one-cycle pulse consuming lane i result.
REQ-015 SHALL have ports fb_valid  output  1, fb_addr  output  $clog2(WIDTH*HEIGHT), fb_pixel  output  16  framebuffer write request.
REQ-016 SHALL have port fb_ready  input  1  framebuffer accepts the write when fb_valid and fb_ready are both high.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-018 SHALL, in IDLE with frame_start high, clear the pixel counters to (0,0) and outstanding count to 0, and enter ISSUE next cycle.
REQ-019 SHALL ignore frame_start in every state other than IDLE.
REQ-020 SHALL, in ISSUE, issue at most one pixel per cycle to the lowest-index ready lane at or after the issue round-robin pointer, then set the pointer to that lane+1 modulo NUM_LANES.
REQ-021 SHALL issue pixels in raster order: h increments 0..WIDTH-1, then wraps to 0 with v incremented.
REQ-022 SHALL not issue to a lane in the cycle it is pulsed or while its lane_ready is low.
REQ-023 SHALL enter DRAIN the cycle after issuing pixel (WIDTH-1, HEIGHT-1).
REQ-024 SHALL select returns by a separate round-robin over lanes with lane_done high, acking one lane per cycle only when the fb output register is empty or being accepted that cycle.
REQ-025 SHALL load fb_pixel and fb_addr = lane_v*WIDTH + lane_h from the acked lane, asserting fb_valid the next cycle and holding all three stable until fb_ready.
REQ-026 SHALL track outstanding = issued minus acked, correctly handling issue and ack in the same cycle (net zero).
REQ-027 SHALL leave DRAIN for DONE when outstanding is 0 and fb_valid is low; DONE pulses frame_done for one cycle and returns to IDLE.
REQ-028 SHALL hold busy high in ISSUE, DRAIN and DONE, low in IDLE.
REQ-029 SHALL accept returns in ISSUE and DRAIN, in any lane order; returns may arrive out of raster order.

Reset
REQ-030 SHALL, on rst high, immediately set state IDLE, busy 0, frame_done 0, lane_issue 0, lane_ack 0, fb_valid 0, issue_h/issue_v 0, fb_addr/fb_pixel 0, both round-robin pointers 0, outstanding 0.
REQ-031 SHALL, on rst mid-frame, discard all in-flight results; lanes are reset by the same rst.
REQ-032 SHALL not require frame_start to be low during rst; a frame starts only on a frame_start pulse after rst deasserts.

Configuration
REQ-033 SHALL, with macro RTX_SCHED_PERF_EN defined, add output frame_cycles (32 bits) counting cycles from frame acceptance to frame_done inclusive, updated at frame_done, reset to 0, saturating at all ones.
REQ-034 SHALL, without RTX_SCHED_PERF_EN, omit frame_cycles and its counter entirely; all other behaviour identical.

Verification (WIDTH=4, HEIGHT=2, NUM_LANES=2)
REQ-035 SHALL cover: both lanes always ready, each lane_done 3 cycles after issue, fb_ready=1 -> 8 fb writes, addresses 0..7 each exactly once, frame_done single pulse, busy low after.
REQ-036 SHALL cover: only lane 1 ready -> all lane_issue pulses on bit 1, issue_h/issue_v sequence (0,0),(1,0),(2,0),(3,0),(0,1)...(3,1).
REQ-037 SHALL cover: lane_done on both lanes same cycle, fb_ready held low 5 cycles -> fb_valid/fb_addr/fb_pixel stable, no second ack until first accepted, both results eventually written.
REQ-038 SHALL cover: frame_start pulsed while busy -> ignored, exactly 8 writes, one frame_done.
REQ-039 SHALL cover: rst asserted after 3 issues -> all outputs 0 same cycle, state IDLE; new frame_start restarts at (0,0).
REQ-040 SHALL cover: with RTX_SCHED_PERF_EN, fixed 3-cycle lane latency -> frame_cycles equals the bench-measured frame_start-acceptance-to-frame_done count.

Source files
------------

// File: rtl/rtx_lane_scheduler.sv
// Raster-order pixel issue to a pool of tracer lanes, round-robin result collection
// into a single framebuffer write port. Optional cycle counter under RTX_SCHED_PERF_EN.
module rtx_lane_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_LANES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  output logic                            busy,
  output logic                            frame_done,
  input  logic [NUM_LANES-1:0]            lane_ready,
  output logic [NUM_LANES-1:0]            lane_issue,
  output logic [10:0]                     issue_h,
  output logic [9:0]                      issue_v,
  input  logic [NUM_LANES-1:0]            lane_done,
  input  logic [16*NUM_LANES-1:0]         lane_pixel,
  input  logic [11*NUM_LANES-1:0]         lane_h,
  input  logic [10*NUM_LANES-1:0]         lane_v,
  output logic [NUM_LANES-1:0]            lane_ack,
  output logic                            fb_valid,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] fb_addr,
  output logic [15:0]                     fb_pixel,
  input  logic                            fb_ready
`ifdef RTX_SCHED_PERF_EN
  ,
  output logic [31:0]                     frame_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for frame_start
  // ISSUE | handing out raster coordinates, collecting returns
  // DRAIN | all pixels issued, waiting for outstanding results and fb write
  // DONE  | one-cycle frame_done pulse, back to IDLE

  localparam int ADDR_W = $clog2(WIDTH*HEIGHT);
  localparam int LW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int OUT_W  = $clog2(WIDTH*HEIGHT+1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [10:0]      h_cnt;
  logic [9:0]       v_cnt;
  logic [LW-1:0]    issue_ptr;
  logic [LW-1:0]    ack_ptr;
  logic [OUT_W-1:0] outstanding;

  logic [15:0] pix_arr [NUM_LANES];
  logic [10:0] h_arr   [NUM_LANES];
  logic [9:0]  v_arr   [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_unpack
    assign pix_arr[g] = lane_pixel[16*g +: 16];
    assign h_arr[g]   = lane_h[11*g +: 11];
    assign v_arr[g]   = lane_v[10*g +: 10];
  end

  function automatic logic [LW:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                          input logic [LW-1:0] ptr);
    logic          found;
    logic [LW-1:0] idx;
    logic [LW-1:0] cand;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      cand = LW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [LW-1:0] rr_next(input logic [LW-1:0] idx);
    return (int'(idx) == NUM_LANES-1) ? '0 : idx + LW'(1);
  endfunction

  // A lane pulsed this cycle has not yet dropped ready/done, so it is masked out.
  logic [NUM_LANES-1:0] issue_req;
  logic [NUM_LANES-1:0] ack_req;
  logic                 issue_found;
  logic [LW-1:0]        issue_sel;
  logic                 ack_found;
  logic [LW-1:0]        ack_sel;
  logic                 issue_fire;
  logic                 ack_fire;
  logic                 last_pixel;
  logic                 drain_exit;

  assign issue_req = lane_ready & ~lane_issue;
  assign ack_req   = lane_done & ~lane_ack;
  assign {issue_found, issue_sel} = rr_pick(issue_req, issue_ptr);
  assign {ack_found, ack_sel}     = rr_pick(ack_req, ack_ptr);

  assign issue_fire = (state == ISSUE) && issue_found;
  assign ack_fire   = ((state == ISSUE) || (state == DRAIN)) && ack_found &&
                      (!fb_valid || fb_ready);
  assign last_pixel = (h_cnt == 11'(WIDTH-1)) && (v_cnt == 10'(HEIGHT-1));
  assign drain_exit = (state == DRAIN) && (outstanding == '0) && !fb_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      lane_issue  <= '0;
      lane_ack    <= '0;
      issue_h     <= '0;
      issue_v     <= '0;
      fb_valid    <= 1'b0;
      fb_addr     <= '0;
      fb_pixel    <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      issue_ptr   <= '0;
      ack_ptr     <= '0;
      outstanding <= '0;
    end else begin
      lane_issue <= '0;
      lane_ack   <= '0;
      frame_done <= 1'b0;

      if (fb_valid && fb_ready) fb_valid <= 1'b0;

      if (ack_fire) begin
        lane_ack <= NUM_LANES'(1) << ack_sel;
        ack_ptr  <= rr_next(ack_sel);
        fb_valid <= 1'b1;
        fb_pixel <= pix_arr[ack_sel];
        fb_addr  <= ADDR_W'(32'(v_arr[ack_sel]) * 32'(WIDTH) + 32'(h_arr[ack_sel]));
      end

      case ({issue_fire, ack_fire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (frame_start) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            outstanding <= '0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            lane_issue <= NUM_LANES'(1) << issue_sel;
            issue_ptr  <= rr_next(issue_sel);
            issue_h    <= h_cnt;
            issue_v    <= v_cnt;
            if (last_pixel) begin
              h_cnt <= '0;
              v_cnt <= '0;
              state <= DRAIN;
            end else if (h_cnt == 11'(WIDTH-1)) begin
              h_cnt <= '0;
              v_cnt <= v_cnt + 10'd1;
            end else begin
              h_cnt <= h_cnt + 11'd1;
            end
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RTX_SCHED_PERF_EN
  logic [31:0] cyc_cnt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // cyc_cnt includes the acceptance cycle; +2 at drain exit adds the last DRAIN
  // cycle and the DONE cycle so frame_cycles is valid alongside frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else begin
      case (state)
        IDLE:         if (frame_start) cyc_cnt <= 32'd1;
        ISSUE, DRAIN: cyc_cnt <= sat_add(cyc_cnt, 32'd1);
        default:      ;
      endcase
      if (drain_exit) frame_cycles <= sat_add(cyc_cnt, 32'd2);
    end
  end
`endif

endmodule

// File: tb/tb_rtx_lane_scheduler.sv
// Directed bench for rtx_lane_scheduler at 4x2 pixels, 2 lanes, with a queued lane model
// and a framebuffer scoreboard.
module tb_rtx_lane_scheduler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NL = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b1;
  logic          busy;
  logic          frame_done;
  logic [NL-1:0] lane_ready = '0;
  logic [NL-1:0] lane_issue;
  logic [10:0]   issue_h;
  logic [9:0]    issue_v;
  logic [NL-1:0] lane_done = '0;
  logic [31:0]   lane_pixel;
  logic [21:0]   lane_h;
  logic [19:0]   lane_v;
  logic [NL-1:0] lane_ack;
  logic          fb_valid;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_pixel;
  logic          fb_ready = 1'b1;
`ifdef RTX_SCHED_PERF_EN
  logic [31:0]   frame_cycles;
`endif

  rtx_lane_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_LANES(NL)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .lane_ready(lane_ready), .lane_issue(lane_issue), .issue_h(issue_h), .issue_v(issue_v),
    .lane_done(lane_done), .lane_pixel(lane_pixel), .lane_h(lane_h), .lane_v(lane_v),
    .lane_ack(lane_ack), .fb_valid(fb_valid), .fb_addr(fb_addr), .fb_pixel(fb_pixel),
    .fb_ready(fb_ready)
`ifdef RTX_SCHED_PERF_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int a);
    return {5'(a / W), 11'(a % W)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lane model: in-order result queue per lane, done once the latency has elapsed
  logic [NL-1:0] ready_mask = 2'b11;
  logic          hold_done = 1'b0;
  int            lat = 3;
  int            cyc = 0;
  logic [10:0]   fh   [NL][16];
  logic [9:0]    fv   [NL][16];
  int            fdue [NL][16];
  int            wp   [NL];
  int            rp   [NL];
  logic [15:0]   m_p  [NL];
  logic [10:0]   m_h  [NL];
  logic [9:0]    m_v  [NL];

  assign lane_pixel = {m_p[1], m_p[0]};
  assign lane_h     = {m_h[1], m_h[0]};
  assign lane_v     = {m_v[1], m_v[0]};

  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  int          wr_cnt = 0;
  int          fd_cnt = 0;
  int          ack_cnt = 0;
  int          issue_cnt = 0;
  int          addr_seen [8];
  logic [1:0]  log_lane [32];
  logic [10:0] log_h [32];
  logic [9:0]  log_v [32];
  int          log_cyc [32];
  bit          meas_on = 1'b0;
  int          meas = 0;
  int          meas_final = 0;

  initial begin
    for (int i = 0; i < NL; i++) begin
      wp[i] = 0; rp[i] = 0; m_p[i] = '0; m_h[i] = '0; m_v[i] = '0;
    end
    for (int a = 0; a < 8; a++) addr_seen[a] = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        wp[i] = 0; rp[i] = 0;
      end
      lane_done = '0;
      meas_on = 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (lane_ack[i] && rp[i] != wp[i]) rp[i]++;
        if (lane_issue[i]) begin
          fh[i][wp[i] % 16]   = issue_h;
          fv[i][wp[i] % 16]   = issue_v;
          fdue[i][wp[i] % 16] = cyc + lat;
          wp[i]++;
        end
        if (rp[i] != wp[i] && fdue[i][rp[i] % 16] <= cyc && !hold_done) begin
          lane_done[i] = 1'b1;
          m_h[i] = fh[i][rp[i] % 16];
          m_v[i] = fv[i][rp[i] % 16];
          m_p[i] = {fv[i][rp[i] % 16][4:0], fh[i][rp[i] % 16]};
        end else begin
          lane_done[i] = 1'b0;
        end
      end
      if (lane_issue != '0) begin
        if (issue_cnt < 32) begin
          log_lane[issue_cnt] = lane_issue;
          log_h[issue_cnt]    = issue_h;
          log_v[issue_cnt]    = issue_v;
          log_cyc[issue_cnt]  = cyc;
        end
        issue_cnt++;
      end
      if (lane_ack != '0) ack_cnt++;
      if (fb_valid && fb_ready) begin
        wr_cnt++;
        addr_seen[int'(fb_addr)]++;
        check("fb_pixel", 64'(fb_pixel), 64'(exp_pix(int'(fb_addr))));
      end
      if (frame_done) fd_cnt++;
      if (!meas_on && frame_start && !busy) begin
        meas_on = 1'b1;
        meas = 0;
      end
      if (meas_on) begin
        meas++;
        if (frame_done) begin
          meas_on = 1'b0;
          meas_final = meas;
        end
      end
    end
    lane_ready = ready_mask;
  end

  task automatic clear_stats();
    wr_cnt = 0; fd_cnt = 0; ack_cnt = 0; issue_cnt = 0;
    for (int a = 0; a < 8; a++) addr_seen[a] = 0;
  endtask

  task automatic run_frame(input int extra_at, input int max_cyc);
    int fd0;
    int c;
    fd0 = fd_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    c = 0;
    while (fd_cnt == fd0 && c < max_cyc) begin
      frame_start = (extra_at > 0) &&
                    (c == extra_at || c == extra_at + 4 || c == extra_at + 8);
      tick();
      c++;
    end
    frame_start = 1'b0;
    check("frame_done_seen", 64'(fd_cnt != fd0), 64'd1);
    repeat (4) tick();
  endtask

  function automatic int addrs_once();
    int n;
    n = 0;
    for (int a = 0; a < 8; a++) if (addr_seen[a] == 1) n++;
    return n;
  endfunction

  initial begin
    logic [AW-1:0] a0;
    logic [15:0]   p0;
    int            min_gap;
    int            c;

    // reset with frame_start held high
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", {frame_done, lane_issue, lane_ack, fb_valid, issue_h, issue_v,
                       fb_addr, fb_pixel}, 64'd0);
    rst = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();
    check("no_start_from_rst", 64'(busy), 64'd0);

    // both lanes always ready, 3-cycle latency
    clear_stats();
    run_frame(0, 100);
    check("t1_writes", 64'(wr_cnt), 64'd8);
    check("t1_addr_once", 64'(addrs_once()), 64'd8);
    check("t1_frame_done", 64'(fd_cnt), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_issue_cnt", 64'(issue_cnt), 64'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t1_issue%0d", k), {log_lane[k], log_v[k], log_h[k]},
            {(k % 2 == 0) ? 2'b01 : 2'b10, 10'(k / W), 11'(k % W)});

    // only lane 1 ready
    ready_mask = 2'b10;
    repeat (2) tick();
    clear_stats();
    run_frame(0, 100);
    check("t2_writes", 64'(wr_cnt), 64'd8);
    check("t2_issue_cnt", 64'(issue_cnt), 64'd8);
    min_gap = 1000;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_issue%0d", k), {log_lane[k], log_v[k], log_h[k]},
            {2'b10, 10'(k / W), 11'(k % W)});
      if (k > 0 && log_cyc[k] - log_cyc[k-1] < min_gap) min_gap = log_cyc[k] - log_cyc[k-1];
    end
    check("t2_gap_ge2", 64'(min_gap >= 2), 64'd1);

    // simultaneous lane_done with framebuffer back-pressure
    ready_mask = 2'b11;
    hold_done = 1'b1;
    fb_ready = 1'b0;
    repeat (2) tick();
    clear_stats();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    c = 0;
    while (issue_cnt < 8 && c < 60) begin
      tick();
      c++;
    end
    check("t3_all_issued", 64'(issue_cnt), 64'd8);
    repeat (5) tick();
    hold_done = 1'b0;
    c = 0;
    while (!fb_valid && c < 20) begin
      tick();
      c++;
    end
    check("t3_fb_valid", 64'(fb_valid), 64'd1);
    a0 = fb_addr;
    p0 = fb_pixel;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t3_hold%0d", k), {fb_valid, fb_addr, fb_pixel}, {1'b1, a0, p0});
      check($sformatf("t3_acks%0d", k), 64'(ack_cnt), 64'd1);
    end
    fb_ready = 1'b1;
    c = 0;
    while (fd_cnt == 0 && c < 60) begin
      tick();
      c++;
    end
    repeat (4) tick();
    check("t3_writes", 64'(wr_cnt), 64'd8);
    check("t3_addr_once", 64'(addrs_once()), 64'd8);
    check("t3_frame_done", 64'(fd_cnt), 64'd1);

    // frame_start pulses while busy are ignored
    clear_stats();
    run_frame(2, 100);
    repeat (4) tick();
    check("t4_writes", 64'(wr_cnt), 64'd8);
    check("t4_frame_done", 64'(fd_cnt), 64'd1);
    check("t4_busy_after", 64'(busy), 64'd0);

    // reset after three issues
    clear_stats();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    c = 0;
    while (issue_cnt < 3 && c < 30) begin
      tick();
      c++;
    end
    check("t5_three_issued", 64'(issue_cnt), 64'd3);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_outs", {frame_done, lane_issue, lane_ack, fb_valid, issue_h, issue_v,
                          fb_addr, fb_pixel}, 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("t5_idle_after_rst", 64'(busy), 64'd0);
    clear_stats();
    run_frame(0, 100);
    check("t5_first_issue", {log_lane[0], log_v[0], log_h[0]}, {2'b01, 10'd0, 11'd0});
    check("t5_writes", 64'(wr_cnt), 64'd8);
    check("t5_addr_once", 64'(addrs_once()), 64'd8);

`ifdef RTX_SCHED_PERF_EN
    clear_stats();
    run_frame(0, 100);
    check("t6_frame_cycles", 64'(frame_cycles), 64'(meas_final));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
